sobel_3_3: RTL and testbench
============================

Name: sobel_3_3

Overview:
- Consumes the 72-bit 3x3 pixel window and its valid flag from the line-buffer window stage.
- Produces a per-pixel Sobel gradient magnitude: 8-bit, saturated, optionally binarised by a threshold.
- Forces the image border to zero using pixel and line position counters.
- Sits between the window generator and the downstream fusion/weighting logic.

Parameters:
- IMG_W, 720, active pixels per line (ivalid-high pixels).
- IMG_H, 576, active lines per frame.
- CNT_W, 12, width of the column and row counters.
- BORDER_VAL, 8'd0, output value for border pixels.

Ports:
- iclk  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- ivalid  in  1  window valid (centre-pixel valid from upstream).
- idata_3_3  in  72  window packed as {p11,p12,p13,p21,p22,p23,p31,p32,p33}, 8 bits each, p11 in [71:64].
  - Row 1 is the oldest line (top). Row 3 is the newest line (bottom).
  - Column 3 is the newest pixel (right).
- iframe_start  in  1  single-cycle pulse, coincident with the first valid pixel of a frame.
- ithresh_en  in  1  1 = binary output.
- ithresh  in  8  binarisation threshold.
- ovalid  out  1  output valid.
- odata  out  8  gradient / binary result.
- ocenter  out  8  p22 delayed to align with odata.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All pipeline valid bits, data registers and counters are cleared.
  - ovalid, odata and ocenter read 0 from the next cycle.
  - Reset asserted mid-frame discards any in-flight pixels.
- Latency: fixed 3 clocks from ivalid/idata_3_3 to ovalid/odata/ocenter. The pipeline advances every cycle regardless of ivalid (no stall).
- Stage 1, column and row weighted sums (unsigned 10-bit):
  - L = p11 + 2*p21 + p31
  - R = p13 + 2*p23 + p33
  - T = p11 + 2*p12 + p13
  - B = p31 + 2*p32 + p33
- Stage 2 (11-bit signed):
  - Gx = R - L
  - Gy = B - T
  - Register |Gx| and |Gy|, 10-bit unsigned, maximum 1020.
- Stage 3, magnitude and output select:
  - M = |Gx| + |Gy| (11-bit). S = min(M, 255).
  - If ithresh_en = 1: result = 255 when S >= ithresh, else 0.
  - If the pixel is a border pixel: result = BORDER_VAL, overriding the threshold.
- ithresh and ithresh_en are sampled in stage 3. Changes take effect on the pixel in stage 3 that cycle.
- When ovalid = 0, odata and ocenter are 0.
- Position counters (col, row) are evaluated in stage 1 for each valid pixel:
  - Tagging: if iframe_start = 1 with ivalid = 1, the pixel is tagged col = 0, row = 0. Otherwise it is tagged with the current counter values.
  - After a valid pixel, col increments. At IMG_W-1, col wraps to 0 and row increments. At row IMG_H-1 with col IMG_W-1, both wrap to 0.
  - Counters hold while ivalid = 0. Line gaps of any length are allowed.
  - iframe_start with ivalid = 0 clears both counters; the next valid pixel is col 0, row 0.
- Border condition: col == 0, col == IMG_W-1, row == 0 or row == IMG_H-1. The border flag travels with the pixel through stages 2 and 3.
- A frame longer than IMG_H lines without iframe_start wraps silently; no error flag.

Decomposition:
- Shared package sobel_pkg holds:
  - PIX_W = 8
  - window slice offsets (P11_LSB = 64 … P33_LSB = 0)
  - SUM_W = 10, GRAD_W = 11
  - SAT_MAX = 255
- One sub-module, sobel_pos_cnt: the col/row counters plus border flag generation, parameterised by IMG_W, IMG_H and CNT_W.
- The arithmetic pipeline stays in sobel_3_3.

Test Plan:
- Reset: hold rst_i 2 cycles while ivalid = 1 with a strong edge window -> ovalid = 0 and odata = 0 during reset and for 3 cycles after release. The first output appears 3 cycles after the first post-reset valid input.
- Flat interior window, all pixels 0x80, at col 5 row 5 -> 3 cycles later ovalid = 1, odata = 0, ocenter = 0x80.
- Vertical edge: p11 = p21 = p31 = 0, p13 = p23 = p33 = 255, middle column 0x80, interior position -> Gx = 1020, Gy = 0, odata = 255 (saturated).
- Threshold: p13 = p23 = p33 = 10, all others 0 (M = 40).
  - ithresh_en = 0 -> odata = 40.
  - ithresh_en = 1, ithresh = 40 -> 255.
  - ithresh_en = 1, ithresh = 41 -> 0.
- Border and wrap, instance IMG_W = 8, IMG_H = 4, vertical-edge window on every pixel, 2-cycle ivalid gaps between lines:
  - Outputs at col 0, col 7, row 0 and row 3 are 0.
  - The 12 interior pixels are 255.
  - The 33rd valid pixel (no iframe_start) is tagged col 0, row 0 -> 0.
- Mid-frame resync: assert iframe_start together with ivalid at pixel 10 of line 2 -> that pixel outputs BORDER_VAL. The following pixels count from col 1, row 0 (all border row -> 0 until the row 1 interior pixels).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared widths, window slice offsets and small arithmetic helpers for the Sobel stage.
// Used by the pipeline top and the position counter sub-module.
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_W   = 9 * PIX_W;
    localparam int SUM_W   = 10;
    localparam int GRAD_W  = 11;
    localparam int SAT_MAX = 255;

    localparam int P11_LSB = 64;
    localparam int P12_LSB = 56;
    localparam int P13_LSB = 48;
    localparam int P21_LSB = 40;
    localparam int P22_LSB = 32;
    localparam int P23_LSB = 24;
    localparam int P31_LSB = 16;
    localparam int P32_LSB = 8;
    localparam int P33_LSB = 0;

    function automatic logic [PIX_W-1:0] pix(input logic [WIN_W-1:0] w, input int lsb);
        return w[lsb +: PIX_W];
    endfunction

    // 1-2-1 weighted sum of three pixels; cannot exceed 1020, so 10 bits suffice
    function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // |x - y| of two unsigned sums, i.e. the magnitude of the signed 11-bit difference
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                  input logic [SUM_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/sobel_pos_cnt.sv
// Column/row position tracking for valid pixels; emits a border flag for the pixel presented now.
// Combinational tag, counters update on the clock; no backpressure, holds while vld is low.
module sobel_pos_cnt import sobel_pkg::*; #(
    parameter int IMG_W = 720,
    parameter int IMG_H = 576,
    parameter int CNT_W = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic frame_start,
    output logic border
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] tag_col;
    logic [CNT_W-1:0] tag_row;

    // frame_start retags the current pixel as the origin of a new frame
    assign tag_col = frame_start ? '0 : col;
    assign tag_row = frame_start ? '0 : row;

    assign border = (tag_col == '0) || (tag_col == COL_LAST) ||
                    (tag_row == '0) || (tag_row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (vld) begin
            if (tag_col == COL_LAST) begin
                col <= '0;
                row <= (tag_row == ROW_LAST) ? '0 : tag_row + 1'b1;
            end else begin
                col <= tag_col + 1'b1;
                row <= tag_row;
            end
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

endmodule

// File: rtl/sobel_3_3.sv
// Sobel gradient magnitude (|Gx|+|Gy|, saturated, optional threshold) with border forcing.
// Fixed 3-cycle latency; free-running pipeline, no backpressure or stall.
module sobel_3_3 import sobel_pkg::*; #(
    parameter int               IMG_W      = 720,
    parameter int               IMG_H      = 576,
    parameter int               CNT_W      = 12,
    parameter logic [PIX_W-1:0] BORDER_VAL = 8'd0
) (
    input  logic             iclk,
    input  logic             rst_i,
    input  logic             ivalid,
    input  logic [WIN_W-1:0] idata_3_3,
    input  logic             iframe_start,
    input  logic             ithresh_en,
    input  logic [PIX_W-1:0] ithresh,
    output logic             ovalid,
    output logic [PIX_W-1:0] odata,
    output logic [PIX_W-1:0] ocenter
);

    logic             in_border;

    logic             s1_vld;
    logic             s1_border;
    logic [SUM_W-1:0] s1_l;
    logic [SUM_W-1:0] s1_r;
    logic [SUM_W-1:0] s1_t;
    logic [SUM_W-1:0] s1_b;
    logic [PIX_W-1:0] s1_center;

    logic             s2_vld;
    logic             s2_border;
    logic [SUM_W-1:0] s2_ax;
    logic [SUM_W-1:0] s2_ay;
    logic [PIX_W-1:0] s2_center;

    logic [GRAD_W-1:0] mag;
    logic [PIX_W-1:0]  sat;
    logic [PIX_W-1:0]  result;

    sobel_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_pos_cnt (
        .clk         (iclk),
        .rst         (rst_i),
        .vld         (ivalid),
        .frame_start (iframe_start),
        .border      (in_border)
    );

    // Stage 1: column (L/R) and row (T/B) weighted sums
    always_ff @(posedge iclk) begin
        if (rst_i) begin
            s1_vld    <= 1'b0;
            s1_border <= 1'b0;
            s1_l      <= '0;
            s1_r      <= '0;
            s1_t      <= '0;
            s1_b      <= '0;
            s1_center <= '0;
        end else begin
            s1_vld    <= ivalid;
            s1_border <= in_border;
            s1_l      <= wsum(pix(idata_3_3, P11_LSB), pix(idata_3_3, P21_LSB), pix(idata_3_3, P31_LSB));
            s1_r      <= wsum(pix(idata_3_3, P13_LSB), pix(idata_3_3, P23_LSB), pix(idata_3_3, P33_LSB));
            s1_t      <= wsum(pix(idata_3_3, P11_LSB), pix(idata_3_3, P12_LSB), pix(idata_3_3, P13_LSB));
            s1_b      <= wsum(pix(idata_3_3, P31_LSB), pix(idata_3_3, P32_LSB), pix(idata_3_3, P33_LSB));
            s1_center <= pix(idata_3_3, P22_LSB);
        end
    end

    // Stage 2: |Gx| = |R - L|, |Gy| = |B - T|
    always_ff @(posedge iclk) begin
        if (rst_i) begin
            s2_vld    <= 1'b0;
            s2_border <= 1'b0;
            s2_ax     <= '0;
            s2_ay     <= '0;
            s2_center <= '0;
        end else begin
            s2_vld    <= s1_vld;
            s2_border <= s1_border;
            s2_ax     <= abs_diff(s1_r, s1_l);
            s2_ay     <= abs_diff(s1_b, s1_t);
            s2_center <= s1_center;
        end
    end

    // Stage 3: magnitude, saturation, threshold, then border override last
    assign mag = GRAD_W'(s2_ax) + GRAD_W'(s2_ay);
    assign sat = (mag > GRAD_W'(SAT_MAX)) ? PIX_W'(SAT_MAX) : mag[PIX_W-1:0];

    always_comb begin
        result = sat;
        if (ithresh_en) begin
            result = (sat >= ithresh) ? PIX_W'(SAT_MAX) : '0;
        end
        if (s2_border) begin
            result = BORDER_VAL;
        end
    end

    always_ff @(posedge iclk) begin
        if (rst_i) begin
            ovalid  <= 1'b0;
            odata   <= '0;
            ocenter <= '0;
        end else begin
            ovalid  <= s2_vld;
            odata   <= s2_vld ? result : '0;
            ocenter <= s2_vld ? s2_center : '0;
        end
    end

endmodule

// File: tb/tb_sobel_3_3.sv
// Bench for sobel_3_3 on an 8x4 image: directed steps plus random windows vs. a per-pixel model.
module tb_sobel_3_3;

    localparam int         W  = 8;
    localparam int         H  = 4;
    localparam logic [7:0] BV = 8'd0;

    localparam logic [71:0] VEDGE = {8'd0, 8'h80, 8'd255, 8'd0, 8'h80, 8'd255, 8'd0, 8'h80, 8'd255};
    localparam logic [71:0] FLAT  = {9{8'h80}};
    localparam logic [71:0] THR   = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};

    logic        iclk = 1'b0;
    logic        rst_i;
    logic        ivalid;
    logic [71:0] idata_3_3;
    logic        iframe_start;
    logic        ithresh_en;
    logic [7:0]  ithresh;
    logic        ovalid;
    logic [7:0]  odata;
    logic [7:0]  ocenter;

    sobel_3_3 #(
        .IMG_W      (W),
        .IMG_H      (H),
        .CNT_W      (12),
        .BORDER_VAL (BV)
    ) dut (
        .iclk         (iclk),
        .rst_i        (rst_i),
        .ivalid       (ivalid),
        .idata_3_3    (idata_3_3),
        .iframe_start (iframe_start),
        .ithresh_en   (ithresh_en),
        .ithresh      (ithresh),
        .ovalid       (ovalid),
        .odata        (odata),
        .ocenter      (ocenter)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        bit vld;
        int s;
        bit border;
        int center;
    } exp_t;

    exp_t hist[$];
    int   pidx  = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_sat = 0;

    // k = 0..8 selects p11, p12, p13, p21, ... p33
    function automatic int px(input logic [71:0] w, input int k);
        logic [7:0] b;
        b = w[(71 - 8 * k) -: 8];
        return int'(b);
    endfunction

    function automatic int sobel_sat(input logic [71:0] w);
        int l, r, t, b, gx, gy, m;
        l  = px(w, 0) + 2 * px(w, 3) + px(w, 6);
        r  = px(w, 2) + 2 * px(w, 5) + px(w, 8);
        t  = px(w, 0) + 2 * px(w, 1) + px(w, 2);
        b  = px(w, 6) + 2 * px(w, 7) + px(w, 8);
        gx = r - l;
        gy = b - t;
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // One clock: record the model entry for the current inputs, then check the output 2 entries back
    task automatic tick();
        exp_t e;
        exp_t z;
        int   col, row, ed, ec;
        z = '{0, 0, 0, 0};
        e = z;
        if (rst_i) begin
            hist.delete();
            hist.push_back(z);
            pidx = 0;
        end else begin
            if (ivalid) begin
                if (iframe_start) pidx = 0;
                col      = pidx % W;
                row      = (pidx / W) % H;
                e.vld    = 1'b1;
                e.s      = sobel_sat(idata_3_3);
                e.border = (col == 0) || (col == W - 1) || (row == 0) || (row == H - 1);
                e.center = px(idata_3_3, 4);
                pidx     = (pidx + 1) % (W * H);
            end else if (iframe_start) begin
                pidx = 0;
            end
            hist.push_back(e);
        end
        @(posedge iclk);
        #1;
        e = z;
        if (hist.size() >= 3) e = hist.pop_front();
        ed = !e.vld ? 0 : e.border ? int'(BV) : ithresh_en ? ((e.s >= int'(ithresh)) ? 255 : 0) : e.s;
        ec = e.vld ? e.center : 0;
        n_vec++;
        assert ({ovalid, odata, ocenter} === {e.vld, 8'(ed), 8'(ec)}) else begin
            n_err++;
            $error("FAIL pipe_out: observed v=%0d d=%0d c=%0d, expected v=%0d d=%0d c=%0d",
                   ovalid, odata, ocenter, e.vld, ed, ec);
        end
        if (ovalid && odata == 8'd255) n_sat++;
    endtask

    task automatic drv(input logic v, input logic [71:0] w, input logic fs);
        ivalid       = v;
        idata_3_3    = w;
        iframe_start = fs;
        tick();
    endtask

    task automatic chk(input string tag, input logic [16:0] exp_out);
        n_vec++;
        assert ({ovalid, odata, ocenter} === exp_out) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", tag, {ovalid, odata, ocenter}, exp_out);
        end
    endtask

    task automatic chk_cnt(input string tag, input int got, input int want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        logic [71:0] w;
        rst_i        = 1'b1;
        ivalid       = 1'b0;
        idata_3_3    = '0;
        iframe_start = 1'b0;
        ithresh_en   = 1'b0;
        ithresh      = 8'd0;

        // Reset held two cycles with a strong edge window on the input
        drv(1'b1, VEDGE, 1'b0);
        drv(1'b1, VEDGE, 1'b0);
        chk("reset_out", 17'h0);
        rst_i = 1'b0;

        // Frame 1: pixels 0..12 vertical edge
        drv(1'b1, VEDGE, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            drv(1'b1, VEDGE, 1'b0);
            if (i == 2) chk("first_out", {1'b1, 8'h00, 8'h80});
        end

        drv(1'b1, FLAT, 1'b0);                       // idx 13: col 5 row 1
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("flat", {1'b1, 8'h00, 8'h80});

        drv(1'b1, VEDGE, 1'b0);                      // idx 14: col 6 row 1
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("vedge_sat", {1'b1, 8'hFF, 8'h80});

        drv(1'b1, VEDGE, 1'b0);
        drv(1'b1, VEDGE, 1'b0);

        drv(1'b1, THR, 1'b0);                        // idx 17: col 1 row 2
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("thr_off", {1'b1, 8'd40, 8'd0});

        ithresh_en = 1'b1;
        ithresh    = 8'd40;
        drv(1'b1, THR, 1'b0);
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("thr_eq", {1'b1, 8'hFF, 8'd0});

        ithresh = 8'd41;
        drv(1'b1, THR, 1'b0);
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("thr_above", {1'b1, 8'h00, 8'd0});
        ithresh_en = 1'b0;

        for (int i = 20; i <= 31; i++) begin
            drv(1'b1, VEDGE, 1'b0);
            if (i == 23) begin
                drv(1'b0, '0, 1'b0);
                drv(1'b0, '0, 1'b0);
            end
        end

        drv(1'b1, VEDGE, 1'b0);                      // 33rd pixel wraps to col 0 row 0
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk("wrap", {1'b1, 8'h00, 8'h80});

        // Frame 2: full frame of edges with line gaps; only the 12 interior pixels saturate
        n_sat = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) drv(1'b1, VEDGE, (r == 0 && c == 0));
            drv(1'b0, '0, 1'b0);
            drv(1'b0, '0, 1'b0);
        end
        chk_cnt("interior_cnt", n_sat, 12);

        // Random windows, thresholds, gaps, frame starts and occasional resets
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    w[71:64] = 8'($urandom());
                    w[63:32] = $urandom();
                    w[31:0]  = $urandom();
                end
                1: for (int k = 0; k < 9; k++) w[8 * k +: 8] = 8'($urandom_range(0, 40));
                default: w = VEDGE;
            endcase
            rst_i      = ($urandom_range(0, 199) == 0);
            ithresh_en = 1'($urandom_range(0, 1));
            ithresh    = 8'($urandom_range(0, 255));
            drv(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 99) < 3));
        end
        rst_i      = 1'b0;
        ithresh_en = 1'b0;

        // Mid-frame resync at row 2 col 5
        drv(1'b0, '0, 1'b1);
        for (int i = 0; i < 21; i++) drv(1'b1, VEDGE, 1'b0);
        drv(1'b1, VEDGE, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            drv(1'b1, VEDGE, 1'b0);
            if (i == 2) begin
                chk("resync", {1'b1, 8'h00, 8'h80});
                n_sat = 0;
            end
        end
        drv(1'b0, '0, 1'b0);
        drv(1'b0, '0, 1'b0);
        chk_cnt("resync_cnt", n_sat, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
